// File: rtl/axi_dma_rd_burst_sched.sv
// rtl/axi_dma_rd_burst_sched.sv - AXI3 read burst scheduler: splits a DMA read command into 16-beat/4KB-legal INCR bursts
module axi_dma_rd_burst_sched #(
    parameter logic ID_VAL          = 1'b0,
    parameter int   MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_beats,
    input  logic [1:0]  cmd_size,
    output logic        arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [1:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    output logic        rready,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_FIN} state_t;

    localparam logic [3:0] MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [1:0] RESP_OKAY = 2'b00;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [1:0]  arsize_q, arsize_d;
    logic [4:0]  burst_n_q, burst_n_d;
    logic [3:0]  outst_q, outst_d;
    logic        sticky_q, sticky_d;

    logic [1:0]  shift;
    logic [12:0] to4k;
    logic [12:0] lim;
    logic [4:0]  n_calc;
    logic        ar_fire, r_fire, r_last_fire, cmd_illegal;

    assign shift       = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd2;
    assign to4k        = (13'h1000 - {1'b0, addr_q[11:0]}) >> shift;
    assign lim         = (to4k < 13'd16) ? to4k : 13'd16;
    assign n_calc      = (rem_q < {3'b0, lim}) ? rem_q[4:0] : lim[4:0];

    assign ar_fire     = arvalid & arready;
    assign r_fire      = rvalid & rready;
    assign r_last_fire = r_fire & rlast;
    assign cmd_illegal = (cmd_beats == 16'd0)
                       || ((cmd_size == 2'b01) && cmd_addr[0])
                       || (cmd_size[1] && (cmd_addr[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        size_d    = size_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        burst_n_d = burst_n_q;
        outst_d   = outst_q;
        sticky_d  = sticky_q;

        // an rlast with nothing outstanding is dropped from the count but poisons the command
        if (ar_fire && !(r_last_fire && outst_q != 4'd0)) begin
            outst_d = outst_q + 4'd1;
        end else if (!ar_fire && r_last_fire && outst_q != 4'd0) begin
            outst_d = outst_q - 4'd1;
        end
        if (r_fire && rresp != RESP_OKAY) sticky_d = 1'b1;
        if (r_last_fire && outst_q == 4'd0) sticky_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    rem_d    = cmd_beats;
                    size_d   = cmd_size;
                    arsize_d = cmd_size;
                    if (cmd_illegal) begin
                        sticky_d = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                araddr_d  = addr_q;
                arlen_d   = 4'(n_calc - 5'd1);
                burst_n_d = n_calc;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (ar_fire) begin
                    addr_d  = addr_q + ({27'b0, burst_n_q} << shift);
                    rem_d   = rem_q - {11'b0, burst_n_q};
                    state_d = (rem_q == {11'b0, burst_n_q}) ? S_DRAIN : S_CALC;
                end
            end
            // looking at the next count lets done follow the final rlast by one cycle
            S_DRAIN: begin
                if (outst_d == 4'd0) state_d = S_FIN;
            end
            S_FIN: begin
                sticky_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            rem_q     <= 16'd0;
            size_q    <= 2'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 4'd0;
            arsize_q  <= 2'd0;
            burst_n_q <= 5'd0;
            outst_q   <= 4'd0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            size_q    <= size_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            burst_n_q <= burst_n_d;
            outst_q   <= outst_d;
            sticky_q  <= sticky_d;
        end
    end

    // arvalid only rises once a slot is free, and no slot is consumed until it is accepted
    assign arvalid   = (state_q == S_ISSUE) && (outst_q < MAX_OUT);
    assign arid      = ID_VAL;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = arsize_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rready    = (state_q == S_CALC) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_FIN);
    assign err       = (state_q == S_FIN) && sticky_q;

endmodule

// File: tb/tb_axi_dma_rd_burst_sched.sv
// tb/tb_axi_dma_rd_burst_sched.sv - randomized bench for axi_dma_rd_burst_sched against a burst-list reference model
module tb_axi_dma_rd_burst_sched;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [1:0]  cmd_size;
    logic        arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [1:0]  arsize;
    logic        arvalid, arready;
    logic        rvalid, rready, rlast;
    logic [1:0]  rresp;
    logic        busy, done, err;

    axi_dma_rd_burst_sched #(.ID_VAL(1'b0), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .cmd_size(cmd_size),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr[$];
    int          exp_len[$];
    int          r_pend[$];
    int          out_m;
    int          beat_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected burst list straight from the splitting rules: 16-beat cap, no 4KB crossing.
    task automatic build_model(input logic [31:0] a, input int b, input logic [1:0] s, output logic legal);
        logic [31:0] ma;
        int rem, bytes, room, n;
        exp_addr.delete();
        exp_len.delete();
        bytes = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        legal = (b != 0) && ((a % 32'(bytes)) == 0);
        ma = a;
        rem = b;
        if (legal) begin
            while (rem > 0) begin
                room = (4096 - int'(ma[11:0])) / bytes;
                n = (rem < 16) ? rem : 16;
                if (room < n) n = room;
                exp_addr.push_back(ma);
                exp_len.push_back(n - 1);
                ma = ma + 32'(n * bytes);
                rem -= n;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        r_pend.delete();
        out_m = 0;
        beat_in = 0;
    endtask

    task automatic run_cmd(input logic [31:0] a, input int b, input logic [1:0] s, input int ar_pct,
                           input int r_pct, input int bad_beat, input logic [1:0] bad_resp, input int hold);
        logic legal, exp_err, got_done, exp_done_now, exp_av_now, prev_stall, ar_hs, r_hs, hold_on;
        logic [31:0] prev_addr;
        int k, nb, ar_cnt, gbeat;
        build_model(a, b, s, legal);
        nb = exp_addr.size();
        exp_err = !legal || (bad_beat >= 0 && bad_beat < b);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = 16'(b); cmd_size = s;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1; ar_cnt = 0; gbeat = 0; got_done = 0; exp_done_now = 0; exp_av_now = 0; prev_stall = 0;
        prev_addr = 32'd0;
        while (k < 4000 && !got_done) begin
            if (exp_done_now) chk("done_after_last_rlast", done, 1);
            if (exp_av_now)   chk("arvalid_reenable", arvalid, 1);
            if (prev_stall) begin
                chk("arvalid_held", arvalid, 1);
                chk("araddr_stable", araddr, prev_addr);
            end
            if (legal && k == 1) chk("no_ar_in_calc", arvalid, 0);
            if (legal && k == 2) chk("first_ar_latency", arvalid, 1);
            if (!legal) chk("illegal_no_ar", arvalid, 0);
            if (arvalid) chk("ar_slot_free", out_m < MAXO, 1);
            if (hold > 0 && k == hold + 1) begin
                chk("hold_ar_count", ar_cnt, (nb < MAXO) ? nb : MAXO);
                if (nb > MAXO) chk("hold_arvalid_low", arvalid, 0);
            end
            if (done) begin
                got_done = 1;
                chk("err_at_done", err, exp_err);
                chk("bursts_left_at_done", exp_addr.size(), 0);
                chk("bursts_open_at_done", r_pend.size(), 0);
                if (!legal) chk("illegal_done_latency", k <= 2, 1);
            end else begin
                exp_done_now = 0;
                exp_av_now = 0;
                hold_on = (k <= hold);
                arready = hold_on ? 1'b1 : ($urandom_range(0, 99) < ar_pct);
                if (!hold_on && rready && r_pend.size() > 0 && $urandom_range(0, 99) < r_pct) begin
                    rvalid = 1'b1;
                    rlast  = (beat_in == r_pend[0] - 1);
                    rresp  = (gbeat == bad_beat) ? bad_resp : 2'b00;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (ar_hs) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_burst", 1, 0);
                    end else begin
                        chk("araddr", araddr, exp_addr[0]);
                        chk("arlen", arlen, exp_len[0]);
                        chk("arsize", arsize, s);
                        chk("arid", arid, 0);
                        r_pend.push_back(exp_len[0] + 1);
                        void'(exp_addr.pop_front());
                        void'(exp_len.pop_front());
                    end
                    ar_cnt++;
                end
                if (r_hs) begin
                    gbeat++;
                    beat_in++;
                    if (rlast) begin
                        void'(r_pend.pop_front());
                        beat_in = 0;
                        if (out_m == MAXO && !arvalid && exp_addr.size() > 0) exp_av_now = 1;
                        out_m--;
                        if (exp_addr.size() == 0 && r_pend.size() == 0) exp_done_now = 1;
                    end
                end
                if (ar_hs) out_m++;
                prev_stall = arvalid && !arready;
                prev_addr = araddr;
                @(negedge clk);
                k++;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    initial begin
        logic [31:0] ra;
        int rb;
        logic [1:0] rs;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_beats = 16'd0; cmd_size = 2'd0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        out_m = 0; beat_in = 0;
        repeat (2) @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arsize", arsize, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;

        run_cmd(32'h0000_1000, 40, 2'b10, 100, 100, -1, 2'b00, 0);
        run_cmd(32'h0000_0FF8, 10, 2'b10, 100, 100, -1, 2'b00, 0);
        run_cmd(32'h0000_0FFE, 4, 2'b00, 100, 100, -1, 2'b00, 0);
        run_cmd(32'h0000_0FFE, 5, 2'b01, 80, 80, -1, 2'b00, 0);
        run_cmd(32'hFFFF_FFF0, 8, 2'b10, 100, 100, -1, 2'b00, 0);
        run_cmd(32'h0000_2000, 64, 2'b10, 100, 60, -1, 2'b00, 12);
        run_cmd(32'h0000_1000, 40, 2'b10, 70, 70, 19, 2'b10, 0);
        run_cmd(32'h0000_1100, 40, 2'b10, 70, 70, -1, 2'b00, 0);
        run_cmd(32'h0000_3000, 20, 2'b11, 90, 90, 5, 2'b01, 0);
        run_cmd(32'h0000_1000, 0, 2'b10, 100, 100, -1, 2'b00, 0);
        run_cmd(32'h0000_1002, 8, 2'b10, 100, 100, -1, 2'b00, 0);
        run_cmd(32'h0000_1001, 8, 2'b01, 100, 100, -1, 2'b00, 0);

        // reset while a second burst is being offered, with one burst still outstanding
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_5000; cmd_beats = 16'd64; cmd_size = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0; arready = 1'b1;
        rb = 0;
        for (int i = 0; i < 12; i++) begin
            if (arvalid && rb == 1) break;
            if (arvalid) rb++;
            @(negedge clk);
        end
        chk("pre_rst_arvalid", arvalid, 1);
        rst = 1'b1; arready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_issue_arvalid", arvalid, 0);
        chk("rst_issue_busy", busy, 0);
        chk("rst_issue_cmd_ready", cmd_ready, 1);
        chk("rst_issue_rready", rready, 0);
        rvalid = 1'b1; rlast = 1'b1; rresp = 2'b10;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        r_pend.delete(); out_m = 0; beat_in = 0;
        run_cmd(32'h0000_6000, 64, 2'b10, 100, 60, -1, 2'b00, 12);

        for (int t = 0; t < 12; t++) begin
            rs = 2'($urandom_range(0, 3));
            ra = 32'h0000_1000 * 32'($urandom_range(1, 9)) - 32'($urandom_range(0, 40));
            if ($urandom_range(0, 3) != 0) ra = ra & ((rs == 2'b00) ? 32'hFFFF_FFFF : (rs == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            rb = $urandom_range(0, 80);
            run_cmd(ra, rb, rs, $urandom_range(30, 100), $urandom_range(30, 100),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 79) : -1,
                    2'($urandom_range(1, 3)), ($urandom_range(0, 1) == 0) ? 8 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
